// File: rtl/id_bypass_scoreboard_pkg.sv
// ---------------------------------------------------------------------------
// id_bypass_scoreboard_pkg
//   Shared encodings for the ID-stage bypass scoreboard.
//   - Result classes carried by every tracked writer (CLS_*).
//   - Register-number width and the hard-wired zero register.
//   - Control-field widths of one scoreboard slot.
// ---------------------------------------------------------------------------
package id_bypass_scoreboard_pkg;

    localparam int REG_W = 5;
    localparam int CLS_W = 2;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    // Result class: tells the scoreboard when a writer's value comes into existence.
    localparam logic [CLS_W-1:0] CLS_NONE = 2'd0;  // never produces a forwardable value
    localparam logic [CLS_W-1:0] CLS_ALU  = 2'd1;  // valid once it leaves EX
    localparam logic [CLS_W-1:0] CLS_PC4  = 2'd2;  // link value, known already at ID
    localparam logic [CLS_W-1:0] CLS_LOAD = 2'd3;  // valid once it leaves MEM

endpackage

// File: rtl/id_bypass_scoreboard_slot_match.sv
// ---------------------------------------------------------------------------
// bypass_slot_match
//   Compares one ID source register against every scoreboard slot and picks
//   the youngest matching writer.
//   Ports:
//     i_src        source register number
//     i_use        source is actually consumed at ID this cycle
//     i_rf_data    raw register-file read data for this source
//     i_vld/i_rdy  per-slot valid / value-ready flags (index 0 = youngest)
//     i_dst        per-slot destination register
//     i_data       per-slot captured result
//     o_hit        value taken from the scoreboard
//     o_data       corrected operand
//     o_stall_req  youngest writer exists but its value is not produced yet
// ---------------------------------------------------------------------------
module bypass_slot_match
    import id_bypass_scoreboard_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 3
) (
    input  logic [REG_W-1:0]              i_src,
    input  logic                          i_use,
    input  logic [DATA_W-1:0]             i_rf_data,
    input  logic [DEPTH-1:0]              i_vld,
    input  logic [DEPTH-1:0]              i_rdy,
    input  logic [DEPTH-1:0][REG_W-1:0]   i_dst,
    input  logic [DEPTH-1:0][DATA_W-1:0]  i_data,
    output logic                          o_hit,
    output logic [DATA_W-1:0]             o_data,
    output logic                          o_stall_req
);

    logic              w_found;
    logic              w_rdy;
    logic [DATA_W-1:0] w_sel;

    // Walk oldest to youngest so a younger match overwrites an older one.
    // An older ready value must never leak past a younger unready writer.
    always_comb begin
        w_found = 1'b0;
        w_rdy   = 1'b0;
        w_sel   = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (i_vld[k] && (i_dst[k] == i_src) && (i_src != REG_ZERO)) begin
                w_found = 1'b1;
                w_rdy   = i_rdy[k];
                w_sel   = i_data[k];
            end
        end
    end

    assign o_hit       = w_found && w_rdy;
    assign o_data      = o_hit ? w_sel : i_rf_data;
    assign o_stall_req = w_found && !w_rdy && i_use;

endmodule

// File: rtl/id_bypass_scoreboard.sv
// ---------------------------------------------------------------------------
// id_bypass_scoreboard
//   ID-stage operand bypass with its own in-flight write scoreboard. Tracks
//   the last DEPTH register writers issued from ID (slot 1 = EX, 2 = MEM,
//   3 = WB, ...), captures their results as they are produced, forwards the
//   youngest matching value to each ID source and stalls ID when that value
//   does not exist yet.
//   Ports:
//     clk, rstn                 clock, asynchronous active-low reset
//     pipe_hold                 whole pipeline frozen: slots hold, no capture
//     id_valid/id_regwrite      ID instruction present / writes a register
//     id_dst, id_class, id_pc   ID writer description
//     id_src_reg, id_use        source numbers (5 bits each) and use flags
//     id_rf_data                raw register-file data per source
//     ex_alu_result             ALU result of the slot-1 instruction
//     mem_rdata                 load data of the slot-2 instruction
//     fwd_data, fwd_hit         corrected operands / taken-from-scoreboard
//     id_stall                  hold PC/IF/ID, bubble into EX
//   Optional build macro BYPASS_PERF_EN adds perf_stall_cnt and perf_fwd_cnt.
// ---------------------------------------------------------------------------
module id_bypass_scoreboard
    import id_bypass_scoreboard_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 3
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        pipe_hold,
    input  logic                        id_valid,
    input  logic                        id_regwrite,
    input  logic [REG_W-1:0]            id_dst,
    input  logic [CLS_W-1:0]            id_class,
    input  logic [DATA_W-1:0]           id_pc,
    input  logic [NUM_SRC*REG_W-1:0]    id_src_reg,
    input  logic [NUM_SRC-1:0]          id_use,
    input  logic [NUM_SRC*DATA_W-1:0]   id_rf_data,
    input  logic [DATA_W-1:0]           ex_alu_result,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic [NUM_SRC*DATA_W-1:0]   fwd_data,
    output logic [NUM_SRC-1:0]          fwd_hit,
`ifdef BYPASS_PERF_EN
    output logic [31:0]                 perf_stall_cnt,
    output logic [31:0]                 perf_fwd_cnt,
`endif
    output logic                        id_stall
);

    // Slot storage, index 0 = slot 1 (EX), index DEPTH-1 = oldest tracked.
    logic [DEPTH-1:0]              r_vld;
    logic [DEPTH-1:0]              r_rdy;
    logic [DEPTH-1:0][REG_W-1:0]   r_dst;
    logic [DEPTH-1:0][DATA_W-1:0]  r_data;
    logic [CLS_W-1:0]              r_cls [DEPTH];

    logic [NUM_SRC-1:0] w_stall_req;
    logic               w_advance;
    logic               w_load;

    assign w_advance = !pipe_hold;
    // A stalled ID instruction is not issued; a bubble enters EX instead.
    assign w_load    = id_valid && !id_stall && id_regwrite && (id_dst != REG_ZERO);
    assign id_stall  = id_valid && (|w_stall_req);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_vld  <= '0;
            r_rdy  <= '0;
            r_dst  <= '0;
            r_data <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_cls[k] <= CLS_NONE;
            end
        end else if (w_advance) begin
            if (w_load) begin
                r_vld[0]  <= 1'b1;
                r_dst[0]  <= id_dst;
                r_cls[0]  <= id_class;
                r_data[0] <= id_pc + DATA_W'(4);
                r_rdy[0]  <= (id_class == CLS_PC4);
            end else begin
                r_vld[0]  <= 1'b0;
                r_dst[0]  <= REG_ZERO;
                r_cls[0]  <= CLS_NONE;
                r_data[0] <= '0;
                r_rdy[0]  <= 1'b0;
            end

            for (int k = 1; k < DEPTH; k++) begin
                r_vld[k]  <= r_vld[k-1];
                r_dst[k]  <= r_dst[k-1];
                r_cls[k]  <= r_cls[k-1];
                r_data[k] <= r_data[k-1];
                r_rdy[k]  <= r_rdy[k-1];
            end

            // Result capture on the way out of EX and MEM; these later
            // assignments override the plain copy above.
            if (r_cls[0] == CLS_ALU) begin
                r_data[1] <= ex_alu_result;
                r_rdy[1]  <= 1'b1;
            end
            if (r_cls[1] == CLS_LOAD) begin
                r_data[2] <= mem_rdata;
                r_rdy[2]  <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        bypass_slot_match #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_match (
            .i_src       (id_src_reg[REG_W*i +: REG_W]),
            .i_use       (id_use[i]),
            .i_rf_data   (id_rf_data[DATA_W*i +: DATA_W]),
            .i_vld       (r_vld),
            .i_rdy       (r_rdy),
            .i_dst       (r_dst),
            .i_data      (r_data),
            .o_hit       (fwd_hit[i]),
            .o_data      (fwd_data[DATA_W*i +: DATA_W]),
            .o_stall_req (w_stall_req[i])
        );
    end

`ifdef BYPASS_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_fwd_cnt;
    logic [31:0] w_fwd_inc;

    // Forwards are counted only when the consuming instruction really issues.
    always_comb begin
        w_fwd_inc = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_fwd_inc = w_fwd_inc + 32'(fwd_hit[i] & id_use[i]);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stall_cnt <= '0;
            r_fwd_cnt   <= '0;
        end else if (w_advance) begin
            if (id_stall) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end else if (id_valid) begin
                r_fwd_cnt <= r_fwd_cnt + w_fwd_inc;
            end
        end
    end

    assign perf_stall_cnt = r_stall_cnt;
    assign perf_fwd_cnt   = r_fwd_cnt;
`endif

endmodule

// File: tb/tb_id_bypass_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_id_bypass_scoreboard
//   Directed bench for id_bypass_scoreboard (DATA_W=32, NUM_SRC=2, DEPTH=3).
//   Inputs change 1 time unit after the rising edge; outputs are checked a
//   further unit later, well before the next edge.
// ---------------------------------------------------------------------------
module tb_id_bypass_scoreboard;

    localparam int DATA_W  = 32;
    localparam int NUM_SRC = 2;
    localparam int DEPTH   = 3;

    localparam logic [1:0] C_NONE = 2'd0;
    localparam logic [1:0] C_ALU  = 2'd1;
    localparam logic [1:0] C_PC4  = 2'd2;
    localparam logic [1:0] C_LOAD = 2'd3;

    localparam logic [31:0] RF0 = 32'h1111_1111;
    localparam logic [31:0] RF1 = 32'h2222_2222;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic                       pipe_hold;
    logic                       id_valid;
    logic                       id_regwrite;
    logic [4:0]                 id_dst;
    logic [1:0]                 id_class;
    logic [DATA_W-1:0]          id_pc;
    logic [NUM_SRC*5-1:0]       id_src_reg;
    logic [NUM_SRC-1:0]         id_use;
    logic [NUM_SRC*DATA_W-1:0]  id_rf_data;
    logic [DATA_W-1:0]          ex_alu_result;
    logic [DATA_W-1:0]          mem_rdata;
    logic [NUM_SRC*DATA_W-1:0]  fwd_data;
    logic [NUM_SRC-1:0]         fwd_hit;
    logic                       id_stall;
`ifdef BYPASS_PERF_EN
    logic [31:0]                perf_stall_cnt;
    logic [31:0]                perf_fwd_cnt;
`endif

    id_bypass_scoreboard #(
        .DATA_W  (DATA_W),
        .NUM_SRC (NUM_SRC),
        .DEPTH   (DEPTH)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .pipe_hold      (pipe_hold),
        .id_valid       (id_valid),
        .id_regwrite    (id_regwrite),
        .id_dst         (id_dst),
        .id_class       (id_class),
        .id_pc          (id_pc),
        .id_src_reg     (id_src_reg),
        .id_use         (id_use),
        .id_rf_data     (id_rf_data),
        .ex_alu_result  (ex_alu_result),
        .mem_rdata      (mem_rdata),
        .fwd_data       (fwd_data),
        .fwd_hit        (fwd_hit),
`ifdef BYPASS_PERF_EN
        .perf_stall_cnt (perf_stall_cnt),
        .perf_fwd_cnt   (perf_fwd_cnt),
`endif
        .id_stall       (id_stall)
    );

    // ---------------- counters ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic id_set(input logic v, input logic rw, input logic [4:0] dst,
                          input logic [1:0] cls, input logic [31:0] pc,
                          input logic [4:0] s0, input logic [4:0] s1,
                          input logic [1:0] use_v);
        id_valid    = v;
        id_regwrite = rw;
        id_dst      = dst;
        id_class    = cls;
        id_pc       = pc;
        id_src_reg  = {s1, s0};
        id_use      = use_v;
    endtask

    task automatic id_idle();
        id_set(1'b0, 1'b0, 5'd0, C_NONE, 32'h0, 5'd0, 5'd0, 2'b00);
    endtask

    task automatic drain();
        id_idle();
        ex_alu_result = '0;
        mem_rdata     = '0;
        for (int i = 0; i < DEPTH; i++) tick();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rstn          = 1'b1;
        pipe_hold     = 1'b0;
        ex_alu_result = '0;
        mem_rdata     = '0;
        id_rf_data    = {RF1, RF0};
        id_idle();
        #2 rstn = 1'b0;

        // Reset state: empty scoreboard, raw RF data passes through.
        id_set(1'b1, 1'b0, 5'd0, C_NONE, 32'h0, 5'd8, 5'd9, 2'b11);
        #1;
        chk("rst_stall", {63'd0, id_stall}, 64'd0);
        chk("rst_hit",   {62'd0, fwd_hit},  64'd0);
        chk("rst_data",  fwd_data,          {RF1, RF0});
        tick();
        tick();
        @(negedge clk) rstn = 1'b1;

        // ---- ALU chain: addu r8 ; beq r8,r0 ----
        id_set(1'b1, 1'b1, 5'd8, C_ALU, 32'h1000, 5'd1, 5'd2, 2'b11);
        #1;
        chk("alu_issue_stall", {63'd0, id_stall}, 64'd0);
        tick();
        id_set(1'b1, 1'b0, 5'd0, C_NONE, 32'h1004, 5'd8, 5'd0, 2'b11);
        ex_alu_result = 32'h10;
        #1;
        chk("alu_c1_stall", {63'd0, id_stall}, 64'd1);
        chk("alu_c1_hit",   {62'd0, fwd_hit},  64'd0);
        chk("alu_c1_data0", {32'd0, fwd_data[31:0]}, {32'd0, RF0});
        tick();
        ex_alu_result = 32'h0;
        #1;
        chk("alu_c2_stall", {63'd0, id_stall}, 64'd0);
        chk("alu_c2_hit",   {62'd0, fwd_hit},  64'd1);
        chk("alu_c2_data",  fwd_data,          {RF1, 32'h10});
        tick();
        drain();

        // ---- Load-use: lw r9 ; jr r9 ----
        id_set(1'b1, 1'b1, 5'd9, C_LOAD, 32'h2000, 5'd1, 5'd0, 2'b01);
        tick();
        id_set(1'b1, 1'b0, 5'd0, C_NONE, 32'h2004, 5'd9, 5'd0, 2'b01);
        #1;
        chk("ld_c1_stall", {63'd0, id_stall}, 64'd1);
        tick();
        mem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("ld_c2_stall", {63'd0, id_stall}, 64'd1);
        chk("ld_c2_hit",   {62'd0, fwd_hit},  64'd0);
        tick();
        mem_rdata = 32'h0;
        #1;
        chk("ld_c3_stall", {63'd0, id_stall}, 64'd0);
        chk("ld_c3_hit",   {62'd0, fwd_hit},  64'd1);
        chk("ld_c3_data0", {32'd0, fwd_data[31:0]}, {32'd0, 32'hDEAD_BEEF});
        tick();
        drain();

        // ---- jal at 0x3000 (r31) ; jr r31 ----
        id_set(1'b1, 1'b1, 5'd31, C_PC4, 32'h3000, 5'd0, 5'd0, 2'b00);
        tick();
        id_set(1'b1, 1'b0, 5'd0, C_NONE, 32'h3004, 5'd31, 5'd0, 2'b01);
        #1;
        chk("jal_stall", {63'd0, id_stall}, 64'd0);
        chk("jal_hit",   {62'd0, fwd_hit},  64'd1);
        chk("jal_data0", {32'd0, fwd_data[31:0]}, {32'd0, 32'h3004});
        tick();
        drain();

        // ---- Shadowing: addu r5=7 ; lw r5 ; beq r5,r5 ----
        id_set(1'b1, 1'b1, 5'd5, C_ALU, 32'h4000, 5'd1, 5'd0, 2'b01);
        tick();
        id_set(1'b1, 1'b1, 5'd5, C_LOAD, 32'h4004, 5'd1, 5'd0, 2'b01);
        ex_alu_result = 32'd7;
        #1;
        chk("shd_lw_stall", {63'd0, id_stall}, 64'd0);
        tick();
        id_set(1'b1, 1'b0, 5'd0, C_NONE, 32'h4008, 5'd5, 5'd5, 2'b11);
        ex_alu_result = 32'd0;
        #1;
        chk("shd_c1_stall", {63'd0, id_stall}, 64'd1);
        chk("shd_c1_hit",   {62'd0, fwd_hit},  64'd0);
        chk("shd_c1_data",  fwd_data,          {RF1, RF0});
        tick();
        mem_rdata = 32'h55;
        #1;
        chk("shd_c2_stall", {63'd0, id_stall}, 64'd1);
        chk("shd_c2_hit",   {62'd0, fwd_hit},  64'd0);
        tick();
        mem_rdata = 32'h0;
        #1;
        chk("shd_c3_stall", {63'd0, id_stall}, 64'd0);
        chk("shd_c3_hit",   {62'd0, fwd_hit},  64'd3);
        chk("shd_c3_data",  fwd_data,          {32'h55, 32'h55});
        tick();
        drain();

        // ---- r0 destination never tracked ----
        id_set(1'b1, 1'b1, 5'd0, C_ALU, 32'h5000, 5'd1, 5'd0, 2'b01);
        tick();
        id_set(1'b1, 1'b0, 5'd0, C_NONE, 32'h5004, 5'd0, 5'd0, 2'b11);
        ex_alu_result = 32'h99;
        #1;
        chk("r0_stall", {63'd0, id_stall}, 64'd0);
        chk("r0_hit",   {62'd0, fwd_hit},  64'd0);
        chk("r0_data",  fwd_data,          {RF1, RF0});
        tick();
        drain();

        // ---- id_use=0: no stall, forwarding still reported ----
        id_set(1'b1, 1'b1, 5'd6, C_ALU, 32'h5100, 5'd1, 5'd0, 2'b01);
        tick();
        id_set(1'b1, 1'b0, 5'd0, C_NONE, 32'h5104, 5'd6, 5'd0, 2'b00);
        ex_alu_result = 32'h66;
        #1;
        chk("nouse_c1_stall", {63'd0, id_stall}, 64'd0);
        chk("nouse_c1_hit",   {62'd0, fwd_hit},  64'd0);
        tick();
        ex_alu_result = 32'h0;
        #1;
        chk("nouse_c2_stall", {63'd0, id_stall}, 64'd0);
        chk("nouse_c2_hit",   {62'd0, fwd_hit},  64'd1);
        chk("nouse_c2_data0", {32'd0, fwd_data[31:0]}, {32'd0, 32'h66});
        tick();
        drain();

        // ---- pipe_hold for 3 cycles in the middle of a load-use ----
        id_set(1'b1, 1'b1, 5'd9, C_LOAD, 32'h6000, 5'd1, 5'd0, 2'b01);
        tick();
        id_set(1'b1, 1'b0, 5'd0, C_NONE, 32'h6004, 5'd9, 5'd0, 2'b01);
        #1;
        chk("hold_c1_stall", {63'd0, id_stall}, 64'd1);
        tick();
        pipe_hold = 1'b1;
        mem_rdata = 32'hCAFE_0000;   // must not be captured while frozen
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_frozen_stall", {63'd0, id_stall}, 64'd1);
            chk("hold_frozen_hit",   {62'd0, fwd_hit},  64'd0);
            tick();
        end
        pipe_hold = 1'b0;
        mem_rdata = 32'h1234_5678;
        #1;
        chk("hold_rel_stall", {63'd0, id_stall}, 64'd1);
        tick();
        mem_rdata = 32'h0;
        #1;
        chk("hold_done_stall", {63'd0, id_stall}, 64'd0);
        chk("hold_done_data0", {32'd0, fwd_data[31:0]}, {32'd0, 32'h1234_5678});
        tick();
        drain();

        // ---- async reset with three valid slots ----
        id_set(1'b1, 1'b1, 5'd10, C_ALU, 32'h7000, 5'd1, 5'd0, 2'b01);
        tick();
        id_set(1'b1, 1'b1, 5'd11, C_ALU, 32'h7004, 5'd1, 5'd0, 2'b01);
        ex_alu_result = 32'hA0;
        tick();
        id_set(1'b1, 1'b1, 5'd12, C_ALU, 32'h7008, 5'd1, 5'd0, 2'b01);
        ex_alu_result = 32'hB0;
        tick();
        ex_alu_result = 32'h0;
        id_set(1'b1, 1'b0, 5'd0, C_NONE, 32'h700C, 5'd10, 5'd11, 2'b11);
        #1;
        chk("prerst_hit",  {62'd0, fwd_hit}, 64'd3);
        chk("prerst_data", fwd_data,         {32'hB0, 32'hA0});
        rstn = 1'b0;
        #1;
        chk("arst_stall", {63'd0, id_stall}, 64'd0);
        chk("arst_hit",   {62'd0, fwd_hit},  64'd0);
        chk("arst_data",  fwd_data,          {RF1, RF0});
`ifdef BYPASS_PERF_EN
        chk("arst_perf_stall", {32'd0, perf_stall_cnt}, 64'd0);
        chk("arst_perf_fwd",   {32'd0, perf_fwd_cnt},   64'd0);
`endif
        tick();
        rstn = 1'b1;
        id_set(1'b1, 1'b0, 5'd0, C_NONE, 32'h7010, 5'd10, 5'd12, 2'b11);
        #1;
        chk("postrst_stall", {63'd0, id_stall}, 64'd0);
        chk("postrst_hit",   {62'd0, fwd_hit},  64'd0);
        chk("postrst_data",  fwd_data,          {RF1, RF0});
        tick();
        drain();

        // ---------------- final report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
